la_checkpoint_ctrl: RTL

User-area block that takes commands from the management SoC over the logic-analyzer (LA) probes and drives a 16-bit checkpoint word onto the user GPIOs. Firmware drives a command word and a toggle strobe, and the block runs SET/ADD/COUNT/CMP operations on the checkpoint register. The checkpoint word goes out on `io_out` (wired to mprj_io[31:16]), where the chip-level testbench monitors progress values. Status and an acknowledge toggle are read back over `la_data_out`.

---
 rtl/la_checkpoint_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/la_checkpoint_ctrl.sv
// Checkpoint register driven by LA-probe commands from the management SoC.
// The checkpoint word goes to the user GPIOs; status and the ack toggle are read back over LA.
module la_checkpoint_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [63:0]       la_data_in,
  input  logic [63:0]       la_oenb,
  output logic [63:0]       la_data_out,
  output logic [DATA_W-1:0] io_out,
  output logic [DATA_W-1:0] io_oeb
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_SET   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_COUNT = 4'd3;
  localparam logic [3:0] OP_CMP   = 4'd4;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [1:0]        state;
  logic [3:0]        op;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] remain;
  logic              match;
  logic              err;
  logic              busy;
  logic              ack;
  logic              req_seen;
  logic              armed;
  logic              oe_on;
  logic [15:0]       cmd_cnt;
  logic [15:0]       chk_ext;
  logic              req_pending;
  logic              unused_bits;

  assign req_pending = ~la_oenb[32] & (la_data_in[32] != req_seen);
  assign unused_bits = ^{la_data_in, la_oenb};

  // EXEC spends its first cycle deciding between launching a count run and
  // arming a single-shot op, so every non-count result lands two edges after acceptance.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      op       <= 4'd0;
      data     <= '0;
      chk      <= '0;
      remain   <= '0;
      match    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      req_seen <= 1'b0;
      armed    <= 1'b0;
      oe_on    <= 1'b0;
      cmd_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_pending) begin
            op       <= la_data_in[31:28];
            data     <= la_data_in[DATA_W-1:0];
            req_seen <= la_data_in[32];
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (!armed) begin
            if (op == OP_COUNT && data != '0) begin
              remain <= data;
              state  <= RUN;
            end else begin
              armed <= 1'b1;
            end
          end else begin
            armed <= 1'b0;
            case (op)
              OP_SET: begin
                chk   <= data;
                match <= 1'b0;
                err   <= 1'b0;
              end
              OP_ADD:           chk   <= chk + data;
              OP_CMP:           match <= (chk == data);
              OP_NOP, OP_COUNT: ;
              default:          err   <= 1'b1;
            endcase
            ack     <= ~ack;
            busy    <= 1'b0;
            cmd_cnt <= cmd_cnt + 16'd1;
            oe_on   <= 1'b1;
            state   <= IDLE;
          end
        end
        RUN: begin
          chk    <= chk + ONE;
          remain <= remain - ONE;
          if (remain == ONE) begin
            ack     <= ~ack;
            busy    <= 1'b0;
            cmd_cnt <= cmd_cnt + 16'd1;
            oe_on   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    chk_ext = 16'd0;
    chk_ext[DATA_W-1:0] = chk;
  end

  assign la_data_out = {cmd_cnt, 15'd0, ack, 13'd0, busy, err, match, chk_ext};
  assign io_out      = chk;
  assign io_oeb      = {DATA_W{~oe_on}};

endmodule
